// File: rtl/cw305_reg_arbiter_if.sv
// cw305_reg_arbiter_if: one CW305 register-bus port. It bundles address,
// byte count, write data, read data and the read/write/addrvalid strobes.
//   master : drives address/bytecnt/datao/read/write/addrvalid, receives datai
//   slave  : receives those fields, drives datai
interface cw305_reg_arbiter_if #(
  parameter int pADDR_WIDTH   = 21,
  parameter int pBYTECNT_SIZE = 7
);
  logic [pADDR_WIDTH-pBYTECNT_SIZE-1:0] address;
  logic [pBYTECNT_SIZE-1:0]             bytecnt;
  logic [7:0]                           datao;
  logic [7:0]                           datai;
  logic                                 read;
  logic                                 write;
  logic                                 addrvalid;

  modport master (output address, bytecnt, datao, read, write, addrvalid, input datai);
  modport slave  (input address, bytecnt, datao, read, write, addrvalid, output datai);
endinterface

// File: rtl/cw305_reg_arbiter.sv
// cw305_reg_arbiter: shares the CW305 register bus between the USB host and
// an on-chip master. The host path is a zero-latency combinational
// passthrough. The internal master is served only after pGUARD host-quiet
// cycles. A host access during an internal op cancels that op, and the op
// re-issues on its own.
// Ports:
//   usb_clk, rst_n   : clock, async active-low reset
//   host_bus (slave) : host_address/bytecnt/datao/read/write/addrvalid in, host_datai out
//   reg_bus (master) : reg_address/bytecnt/datao/read/write/addrvalid out, reg_datai in
//   int_req/int_we/int_address/int_bytecnt/int_wdata : internal request (held until ack)
//   int_ack, int_rdata : one-cycle completion pulse, with read data on that cycle
//   host_active      : host owns the bus or is inside the guard window
//   retry_cnt        : saturating count of preempted internal ops
module cw305_reg_arbiter #(
  parameter int pADDR_WIDTH   = 21,
  parameter int pBYTECNT_SIZE = 7,
  parameter int pGUARD        = 4,
  parameter int pRETRY_W      = 16
) (
  input  logic                                 usb_clk,
  input  logic                                 rst_n,
  cw305_reg_arbiter_if.slave                   host_bus,
  cw305_reg_arbiter_if.master                  reg_bus,
  input  logic                                 int_req,
  input  logic                                 int_we,
  input  logic [pADDR_WIDTH-pBYTECNT_SIZE-1:0] int_address,
  input  logic [pBYTECNT_SIZE-1:0]             int_bytecnt,
  input  logic [7:0]                           int_wdata,
  output logic                                 int_ack,
  output logic [7:0]                           int_rdata,
  output logic                                 host_active,
  output logic [pRETRY_W-1:0]                  retry_cnt
);
  localparam int AW = pADDR_WIDTH - pBYTECNT_SIZE;
  localparam int QW = $clog2(pGUARD + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, ACK} state_t;
  state_t state, state_nxt;

  logic                     hact, accept;
  logic [QW-1:0]            quiet_cnt;
  logic                     op_we;
  logic [AW-1:0]            op_addr;
  logic [pBYTECNT_SIZE-1:0] op_bc;
  logic [7:0]               op_wdata, rdata_q;
  logic                     drive_int, rd_stb, wr_stb, capture, preempt;

  assign hact        = host_bus.read | host_bus.write;
  assign host_active = hact | (quiet_cnt != '0);
  assign accept      = (state == IDLE) & int_req & ~host_active;

  // state register
  always_ff @(posedge usb_clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // next state: a host access in ISSUE/CAPTURE returns to IDLE without an ack
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = ISSUE;
      ISSUE:   if (hact) state_nxt = IDLE;
               else      state_nxt = op_we ? ACK : CAPTURE;
      CAPTURE: state_nxt = IDLE;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // outputs: the internal op drives the bus only in ISSUE/CAPTURE with no host access
  always_comb begin
    drive_int = 1'b0;
    rd_stb    = 1'b0;
    wr_stb    = 1'b0;
    capture   = 1'b0;
    preempt   = 1'b0;
    int_ack   = 1'b0;
    case (state)
      ISSUE:   if (hact) preempt = 1'b1;
               else begin
                 drive_int = 1'b1;
                 rd_stb    = ~op_we;
                 wr_stb    = op_we;
               end
      CAPTURE: if (hact) preempt = 1'b1;
               else begin
                 drive_int = 1'b1;
                 capture   = 1'b1;
                 int_ack   = 1'b1;
               end
      ACK:     int_ack = 1'b1;
      default: ;
    endcase
  end

  // Read data leaves combinationally on the ack cycle. The registered copy
  // keeps int_rdata stable afterwards.
  assign int_rdata = capture ? reg_bus.datai : rdata_q;

  assign reg_bus.address   = drive_int ? op_addr  : host_bus.address;
  assign reg_bus.bytecnt   = drive_int ? op_bc    : host_bus.bytecnt;
  assign reg_bus.datao     = drive_int ? op_wdata : host_bus.datao;
  assign reg_bus.read      = drive_int ? rd_stb   : host_bus.read;
  assign reg_bus.write     = drive_int ? wr_stb   : host_bus.write;
  assign reg_bus.addrvalid = drive_int | host_bus.addrvalid;
  assign host_bus.datai    = reg_bus.datai;

  // The guard counter starts full after reset, so the first grant waits pGUARD cycles.
  always_ff @(posedge usb_clk or negedge rst_n) begin
    if (!rst_n)              quiet_cnt <= QW'(pGUARD);
    else if (hact)           quiet_cnt <= QW'(pGUARD);
    else if (quiet_cnt != 0) quiet_cnt <= quiet_cnt - 1'b1;
  end

  always_ff @(posedge usb_clk or negedge rst_n) begin
    if (!rst_n) begin
      retry_cnt <= '0;
      rdata_q   <= '0;
      op_we     <= 1'b0;
      op_addr   <= '0;
      op_bc     <= '0;
      op_wdata  <= '0;
    end else begin
      if (preempt && retry_cnt != '1) retry_cnt <= retry_cnt + 1'b1;
      if (capture) rdata_q <= reg_bus.datai;
      if (accept) begin
        op_we    <= int_we;
        op_addr  <= int_address;
        op_bc    <= int_bytecnt;
        op_wdata <= int_wdata;
      end
    end
  end
endmodule

// File: tb/tb_cw305_reg_arbiter.sv
module tb_cw305_reg_arbiter;
  localparam int AW = 14;
  localparam int BW = 7;

  logic          usb_clk = 1'b0;
  logic          rst_n   = 1'b0;
  logic          int_req = 1'b0, int_we = 1'b0;
  logic [AW-1:0] int_address = '0;
  logic [BW-1:0] int_bytecnt = '0;
  logic [7:0]    int_wdata = '0;
  logic          int_ack;
  logic [7:0]    int_rdata;
  logic          host_active;
  logic [1:0]    retry_cnt;
  int            tests = 0, fails = 0;

  cw305_reg_arbiter_if #(.pADDR_WIDTH(21), .pBYTECNT_SIZE(BW)) host_if ();
  cw305_reg_arbiter_if #(.pADDR_WIDTH(21), .pBYTECNT_SIZE(BW)) reg_if ();

  cw305_reg_arbiter #(.pADDR_WIDTH(21), .pBYTECNT_SIZE(BW), .pGUARD(4), .pRETRY_W(2)) dut (
    .usb_clk(usb_clk), .rst_n(rst_n), .host_bus(host_if), .reg_bus(reg_if),
    .int_req(int_req), .int_we(int_we), .int_address(int_address),
    .int_bytecnt(int_bytecnt), .int_wdata(int_wdata), .int_ack(int_ack),
    .int_rdata(int_rdata), .host_active(host_active), .retry_cnt(retry_cnt));

  always #5 usb_clk = ~usb_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step(); @(posedge usb_clk); #1; endtask
  task automatic smp();  @(negedge usb_clk);     endtask

  // step until an internal/host strobe appears; n = cycles taken, -1 on timeout
  task automatic wait_strobe(output int n);
    n = -1;
    for (int i = 1; i <= 20; i++) begin
      step(); smp();
      if (reg_if.read || reg_if.write) begin n = i; break; end
    end
  endtask

  task automatic host_idle();
    host_if.read = 1'b0; host_if.write = 1'b0; host_if.addrvalid = 1'b0;
    host_if.address = '0; host_if.bytecnt = '0; host_if.datao = '0;
  endtask

  task automatic test_reset();
    host_idle();
    host_if.addrvalid = 1'b1; host_if.address = 14'h12; reg_if.datai = 8'h44;
    rst_n = 1'b0;
    repeat (2) @(posedge usb_clk);
    smp();
    tests++; if (int_ack !== 1'b0) begin fails++; $display("FAIL rst_ack: got %0b want 0", int_ack); end
    tests++; if (retry_cnt !== 2'd0) begin fails++; $display("FAIL rst_retry: got %0d want 0", retry_cnt); end
    tests++; if (int_rdata !== 8'h00) begin fails++; $display("FAIL rst_rdata: got %h want 00", int_rdata); end
    tests++; if (host_active !== 1'b1) begin fails++; $display("FAIL rst_hactive: got %0b want 1", host_active); end
    tests++; if (reg_if.address !== 14'h12 || reg_if.addrvalid !== 1'b1) begin fails++; $display("FAIL rst_pass: got addr %h av %0b want 12 1", reg_if.address, reg_if.addrvalid); end
    tests++; if (host_if.datai !== 8'h44) begin fails++; $display("FAIL rst_datai: got %h want 44", host_if.datai); end
    step(); rst_n = 1'b1; host_idle();
    repeat (10) step();
    smp();
    tests++; if (host_active !== 1'b0) begin fails++; $display("FAIL guard_expired: got %0b want 0", host_active); end
  endtask

  task automatic test_write();
    step();
    int_req = 1'b1; int_we = 1'b1; int_address = 14'h05; int_bytecnt = '0; int_wdata = 8'hA5;
    smp();
    tests++; if (reg_if.write !== 1'b0 || int_ack !== 1'b0) begin fails++; $display("FAIL wr_idle: got wr %0b ack %0b want 0 0", reg_if.write, int_ack); end
    step(); smp();
    tests++; if (reg_if.write !== 1'b1 || reg_if.read !== 1'b0) begin fails++; $display("FAIL wr_strobe: got wr %0b rd %0b want 1 0", reg_if.write, reg_if.read); end
    tests++; if (reg_if.address !== 14'h05 || reg_if.datao !== 8'hA5 || reg_if.addrvalid !== 1'b1) begin fails++; $display("FAIL wr_fields: got %h %h %0b want 05 a5 1", reg_if.address, reg_if.datao, reg_if.addrvalid); end
    tests++; if (int_ack !== 1'b0) begin fails++; $display("FAIL wr_early_ack: got %0b want 0", int_ack); end
    step(); smp();
    tests++; if (int_ack !== 1'b1 || reg_if.write !== 1'b0) begin fails++; $display("FAIL wr_ack: got ack %0b wr %0b want 1 0", int_ack, reg_if.write); end
    int_req = 1'b0;
    step(); smp();
    tests++; if (int_ack !== 1'b0 || reg_if.write !== 1'b0) begin fails++; $display("FAIL wr_done: got ack %0b wr %0b want 0 0", int_ack, reg_if.write); end
    tests++; if (retry_cnt !== 2'd0) begin fails++; $display("FAIL wr_retry: got %0d want 0", retry_cnt); end
  endtask

  task automatic test_read();
    step();
    int_req = 1'b1; int_we = 1'b0; int_address = 14'h02; int_bytecnt = 7'd1; reg_if.datai = 8'h3C;
    smp();
    tests++; if (reg_if.read !== 1'b0 || host_if.datai !== 8'h3C) begin fails++; $display("FAIL rd_idle: got rd %0b datai %h want 0 3c", reg_if.read, host_if.datai); end
    step(); smp();
    tests++; if (reg_if.read !== 1'b1 || reg_if.address !== 14'h02 || int_ack !== 1'b0) begin fails++; $display("FAIL rd_strobe: got rd %0b addr %h ack %0b want 1 02 0", reg_if.read, reg_if.address, int_ack); end
    step(); smp();
    tests++; if (reg_if.read !== 1'b0 || reg_if.address !== 14'h02 || reg_if.addrvalid !== 1'b1) begin fails++; $display("FAIL rd_capture: got rd %0b addr %h av %0b want 0 02 1", reg_if.read, reg_if.address, reg_if.addrvalid); end
    tests++; if (int_ack !== 1'b1 || int_rdata !== 8'h3C) begin fails++; $display("FAIL rd_ack: got ack %0b data %h want 1 3c", int_ack, int_rdata); end
    int_req = 1'b0;
    step(); reg_if.datai = 8'h11; smp();
    tests++; if (int_ack !== 1'b0 || int_rdata !== 8'h3C) begin fails++; $display("FAIL rd_hold: got ack %0b data %h want 0 3c", int_ack, int_rdata); end
    tests++; if (host_if.datai !== 8'h11) begin fails++; $display("FAIL datai_track: got %h want 11", host_if.datai); end
  endtask

  task automatic test_passthrough();
    step();
    int_req = 1'b1; int_we = 1'b1; int_address = 14'h09; int_wdata = 8'h77;
    host_if.read = 1'b1; host_if.address = 14'h07; host_if.bytecnt = 7'd3; host_if.addrvalid = 1'b1;
    smp();
    tests++; if (reg_if.read !== 1'b1 || reg_if.write !== 1'b0 || reg_if.address !== 14'h07 || reg_if.bytecnt !== 7'd3) begin fails++; $display("FAIL pass_same_cycle: got rd %0b wr %0b addr %h bc %0d want 1 0 07 3", reg_if.read, reg_if.write, reg_if.address, reg_if.bytecnt); end
    step(); smp();
    tests++; if (reg_if.write !== 1'b0 || reg_if.address !== 14'h07) begin fails++; $display("FAIL pass_hold: got wr %0b addr %h want 0 07", reg_if.write, reg_if.address); end
    step(); host_idle(); smp();
    for (int i = 0; i < 4; i++) begin
      tests++; if (host_active !== 1'b1 || reg_if.write !== 1'b0) begin fails++; $display("FAIL pass_guard%0d: got ha %0b wr %0b want 1 0", i, host_active, reg_if.write); end
      step(); smp();
    end
    tests++; if (host_active !== 1'b0 || reg_if.write !== 1'b0) begin fails++; $display("FAIL pass_quiet: got ha %0b wr %0b want 0 0", host_active, reg_if.write); end
    step(); smp();
    tests++; if (reg_if.write !== 1'b1 || reg_if.address !== 14'h09 || reg_if.datao !== 8'h77) begin fails++; $display("FAIL pass_issue: got wr %0b addr %h d %h want 1 09 77", reg_if.write, reg_if.address, reg_if.datao); end
    step(); smp();
    tests++; if (int_ack !== 1'b1) begin fails++; $display("FAIL pass_ack: got %0b want 1", int_ack); end
    int_req = 1'b0;
  endtask

  task automatic test_preempt();
    int n;
    step();
    int_req = 1'b1; int_we = 1'b0; int_address = 14'h0A; reg_if.datai = 8'h5A;
    smp();
    step();
    host_if.write = 1'b1; host_if.address = 14'h0C; host_if.datao = 8'h99; host_if.addrvalid = 1'b1;
    smp();
    tests++; if (reg_if.write !== 1'b1 || reg_if.read !== 1'b0 || reg_if.address !== 14'h0C || reg_if.datao !== 8'h99) begin fails++; $display("FAIL pre_issue_bus: got wr %0b rd %0b addr %h d %h want 1 0 0c 99", reg_if.write, reg_if.read, reg_if.address, reg_if.datao); end
    tests++; if (int_ack !== 1'b0) begin fails++; $display("FAIL pre_issue_ack: got %0b want 0", int_ack); end
    step(); host_idle(); smp();
    tests++; if (retry_cnt !== 2'd1 || int_ack !== 1'b0 || reg_if.read !== 1'b0) begin fails++; $display("FAIL pre_issue_retry: got retry %0d ack %0b rd %0b want 1 0 0", retry_cnt, int_ack, reg_if.read); end
    wait_strobe(n);
    tests++; if (n !== 5 || reg_if.read !== 1'b1 || reg_if.address !== 14'h0A) begin fails++; $display("FAIL pre_reissue1: got cycles %0d rd %0b addr %h want 5 1 0a", n, reg_if.read, reg_if.address); end
    step();
    host_if.write = 1'b1; host_if.address = 14'h0C; host_if.addrvalid = 1'b1;
    smp();
    tests++; if (int_ack !== 1'b0 || reg_if.read !== 1'b0 || reg_if.write !== 1'b1 || reg_if.address !== 14'h0C) begin fails++; $display("FAIL pre_capture_bus: got ack %0b rd %0b wr %0b addr %h want 0 0 1 0c", int_ack, reg_if.read, reg_if.write, reg_if.address); end
    step(); host_idle(); smp();
    tests++; if (retry_cnt !== 2'd2 || int_ack !== 1'b0) begin fails++; $display("FAIL pre_capture_retry: got retry %0d ack %0b want 2 0", retry_cnt, int_ack); end
    wait_strobe(n);
    tests++; if (n !== 5 || reg_if.read !== 1'b1) begin fails++; $display("FAIL pre_reissue2: got cycles %0d rd %0b want 5 1", n, reg_if.read); end
    step(); smp();
    tests++; if (int_ack !== 1'b1 || int_rdata !== 8'h5A) begin fails++; $display("FAIL pre_complete: got ack %0b data %h want 1 5a", int_ack, int_rdata); end
    int_req = 1'b0;
  endtask

  task automatic test_reset_capture();
    int n;
    step();
    int_req = 1'b1; int_we = 1'b0; int_address = 14'h03; reg_if.datai = 8'h6B;
    smp();
    step(); smp();
    tests++; if (reg_if.read !== 1'b1) begin fails++; $display("FAIL rc_issue: got %0b want 1", reg_if.read); end
    step(); rst_n = 1'b0; smp();
    tests++; if (int_ack !== 1'b0 || retry_cnt !== 2'd0 || int_rdata !== 8'h00) begin fails++; $display("FAIL rc_reset: got ack %0b retry %0d data %h want 0 0 00", int_ack, retry_cnt, int_rdata); end
    tests++; if (host_active !== 1'b1 || reg_if.read !== 1'b0) begin fails++; $display("FAIL rc_reset_bus: got ha %0b rd %0b want 1 0", host_active, reg_if.read); end
    step(); rst_n = 1'b1;
    wait_strobe(n);
    tests++; if (n !== 5 || reg_if.address !== 14'h03) begin fails++; $display("FAIL rc_regrant: got cycles %0d addr %h want 5 03", n, reg_if.address); end
    step(); smp();
    tests++; if (int_ack !== 1'b1 || int_rdata !== 8'h6B) begin fails++; $display("FAIL rc_complete: got ack %0b data %h want 1 6b", int_ack, int_rdata); end
    int_req = 1'b0;
  endtask

  task automatic test_saturation();
    int n;
    int exp;
    step();
    int_req = 1'b1; int_we = 1'b0; int_address = 14'h04;
    for (int i = 0; i < 5; i++) begin
      wait_strobe(n);
      tests++; if (n < 1) begin fails++; $display("FAIL sat_issue%0d: got timeout want strobe", i); end
      host_if.write = 1'b1;
      step(); host_if.write = 1'b0; smp();
      exp = (i + 1 > 3) ? 3 : i + 1;
      tests++; if (retry_cnt !== 2'(exp) || int_ack !== 1'b0) begin fails++; $display("FAIL sat_retry%0d: got %0d ack %0b want %0d 0", i, retry_cnt, int_ack, exp); end
    end
    int_req = 1'b0;
    step(); smp();
    tests++; if (retry_cnt !== 2'd3) begin fails++; $display("FAIL sat_hold: got %0d want 3", retry_cnt); end
  endtask

  initial begin
    host_idle();
    reg_if.datai = 8'h00;
    test_reset();
    test_write();
    test_read();
    test_passthrough();
    test_preempt();
    test_reset_capture();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/cw305_reg_arbiter.md
Name: cw305_reg_arbiter

Overview:
- Shares the single CW305 register bus (reg_address/bytecnt/datao/datai/read/write/addrvalid) between two masters.
  - Host: the USB front-end.
  - Internal: an on-chip master, e.g. a trace/DMA engine or a config sequencer.
- Host has absolute, zero-latency priority. The host path is a combinational passthrough, so front-end read timing is unchanged.
- The internal master is served only in host-quiet windows, through a req/ack handshake.
- A host access arriving mid-transaction cancels the internal op without side effects; the op is retried automatically.

Parameters:
- pADDR_WIDTH, 21, full USB address width.
- pBYTECNT_SIZE, 7, byte-count field width.
- pGUARD, 4, host-quiet cycles required before an internal grant (≥1).
- pRETRY_W, 16, retry counter width.

Ports:
- usb_clk  in  1  sole clock.
- rst_n  in  1  asynchronous active-low reset.
- host_address  in  pADDR_WIDTH-pBYTECNT_SIZE  host register address.
- host_bytecnt  in  pBYTECNT_SIZE  host byte count.
- host_datao  in  8  host write data.
- host_datai  out  8  host read data.
- host_read  in  1  host read flag.
- host_write  in  1  host write flag.
- host_addrvalid  in  1  host address valid.
- int_req  in  1  internal request; held until int_ack.
- int_we  in  1  1 = write, 0 = read.
- int_address  in  pADDR_WIDTH-pBYTECNT_SIZE  internal address.
- int_bytecnt  in  pBYTECNT_SIZE  internal byte count.
- int_wdata  in  8  internal write data.
- int_ack  out  1  one-cycle completion pulse.
- int_rdata  out  8  read data; valid when int_ack=1.
- reg_address  out  pADDR_WIDTH-pBYTECNT_SIZE  to register block.
- reg_bytecnt  out  pBYTECNT_SIZE  to register block.
- reg_datao  out  8  to register block.
- reg_datai  in  8  from register block.
- reg_read  out  1  to register block.
- reg_write  out  1  to register block.
- reg_addrvalid  out  1  to register block.
- host_active  out  1  status: host owns or guards the bus.
- retry_cnt  out  pRETRY_W  count of preempted internal ops, saturating.

Behaviour:
- Host activity: hact = host_read | host_write.
  - quiet_cnt loads pGUARD on any hact cycle; otherwise decrements to 0.
  - host_active = hact | (quiet_cnt != 0).
- Bus mux (combinational):
  - hact=1, or state IDLE/ACK: reg_* = host_* passthrough, including host_addrvalid.
  - Otherwise: reg_* = latched internal fields, reg_addrvalid=1.
- host_datai = reg_datai at all times.
- FSM states: IDLE, ISSUE, CAPTURE, ACK.
  - IDLE: if int_req & ~host_active, latch int_we/address/bytecnt/wdata and go to ISSUE.
  - ISSUE, no hact: drive the latched op.
    - Write: reg_write=1, go to ACK.
    - Read: reg_read=1, go to CAPTURE.
  - CAPTURE, no hact: reg_read=0, latched address still driven. Sample reg_datai into int_rdata, pulse int_ack, go to IDLE.
  - ACK: pulse int_ack, go to IDLE.
  - hact=1 in ISSUE or CAPTURE (preempt):
    - Host drives the bus that cycle; no internal strobe reaches reg_*.
    - Go to IDLE with no ack; retry_cnt += 1, saturating at all-ones.
    - int_req is still high, so the op re-issues after the guard expires.
- Latencies:
  - Write: req seen in IDLE → ack 2 cycles later.
  - Read: ack + data 2 cycles after IDLE accept.
  - Minimum back-to-back internal op period: 3 cycles.
- int_req sampled high in IDLE right after an ack is treated as a new request.
- int_* inputs are ignored outside IDLE (latched copy used).
- Reset (async assert, any state): FSM→IDLE, quiet_cnt=pGUARD, int_ack=0, int_rdata=0, retry_cnt=0. The internal path is idle, so reg_* follow host inputs.
  - Any in-flight internal op is dropped without ack.
  - The first internal grant is no earlier than pGUARD cycles after deassertion.
- Simultaneous int_req rise and hact: host wins; no latch.

Test Plan:
- Internal write, host idle, pGUARD=4, reset released 10 cycles prior: int_req, we=1, addr=0x05, bc=0, wdata=0xA5 → reg_write=1 exactly 1 cycle with reg_address=0x05, reg_datao=0xA5; int_ack 1 cycle later; retry_cnt=0.
- Internal read: reg block returns 0x3C at addr 0x02 → reg_read 1 cycle; int_ack + int_rdata=0x3C the following cycle; host_datai tracks reg_datai throughout.
- Host passthrough: host_read at addr 0x07 while int_req pending → reg_* equal host values same cycle; no internal strobe; internal issues only after 4 quiet cycles.
- Preempt in ISSUE (read) and in CAPTURE: assert host_write in that cycle → reg_write from host only, no int_ack, retry_cnt=1 then 2; op completes correctly after guard.
- Reset mid-CAPTURE: drop rst_n → no int_ack, retry_cnt=0, int_rdata=0; after release, pending int_req is served no earlier than cycle 4.
- Saturation: pRETRY_W=2, force 5 preemptions → retry_cnt stops at 3.
